// File: rtl/bs2_msg_pack.sv
// BS2 message packer: writes a BS2 value into each qualifying quote template and
// streams the resulting messages MSB-first, one byte per handshake, lane 1 to 3.
module bs2_msg_pack #(
  parameter int               MSG_BITS = 128,
  parameter int               BS2_BITS = 32,
  parameter int               BS2_LSB  = 32,
  parameter int               MUX_W    = 3,
  parameter logic [MUX_W-1:0] MUX_Q    = MUX_W'(1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                message_en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MSG_BITS-1:0] message_base_1,
  input  logic [MSG_BITS-1:0] message_base_2,
  input  logic [MSG_BITS-1:0] message_base_3,
  input  logic [BS2_BITS-1:0] BS2_1,
  input  logic [BS2_BITS-1:0] BS2_2,
  input  logic [BS2_BITS-1:0] BS2_3,
  input  logic [MUX_W-1:0]    message_mux_control_m1,
  input  logic [MUX_W-1:0]    message_mux_control_m2,
  input  logic [MUX_W-1:0]    message_mux_control_m3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic                out_last,
  output logic [1:0]          out_lane
);

  localparam int NBYTES = MSG_BITS / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [MSG_BITS-1:0] msg_q [3];
  logic [MSG_BITS-1:0] ins [3];
  logic [2:0]          mask_q;
  logic [2:0]          cap_mask;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_inc;
  logic [1:0]          first_lane;
  logic [1:0]          next_lane;
  logic [MSG_BITS-1:0] cur_msg;
  logic [MSG_BITS-1:0] first_msg;
  logic [MSG_BITS-1:0] next_msg;
  logic                capture;
  logic                hs;
  logic                lane_end;
  logic                set_end;

  function automatic logic [MSG_BITS-1:0] insert_bs2(input logic [MSG_BITS-1:0] base,
                                                     input logic [BS2_BITS-1:0] bs2);
    logic [MSG_BITS-1:0] m;
    m = base;
    m[BS2_LSB +: BS2_BITS] = bs2;
    return m;
  endfunction

  // Byte 0 is the most significant byte of the message.
  function automatic logic [7:0] get_byte(input logic [MSG_BITS-1:0] m,
                                          input logic [CNT_W-1:0]    idx);
    logic [MSG_BITS-1:0] s;
    s = m << {idx, 3'b000};
    return s[MSG_BITS-1 -: 8];
  endfunction

  always_comb begin
    ins[0]   = insert_bs2(message_base_1, BS2_1);
    ins[1]   = insert_bs2(message_base_2, BS2_2);
    ins[2]   = insert_bs2(message_base_3, BS2_3);
    cap_mask = {message_en & (message_mux_control_m3 == MUX_Q),
                message_en & (message_mux_control_m2 == MUX_Q),
                message_en & (message_mux_control_m1 == MUX_Q)};
  end

  // Lane sequencing: lowest set bit at capture, next higher set bit at each lane end.
  always_comb begin
    first_lane = 2'd0;
    if (cap_mask[0])      first_lane = 2'd1;
    else if (cap_mask[1]) first_lane = 2'd2;
    else if (cap_mask[2]) first_lane = 2'd3;

    next_lane = 2'd0;
    case (out_lane)
      2'd1: begin
        if (mask_q[1])      next_lane = 2'd2;
        else if (mask_q[2]) next_lane = 2'd3;
      end
      2'd2: begin
        if (mask_q[2]) next_lane = 2'd3;
      end
      default: next_lane = 2'd0;
    endcase
  end

  always_comb begin
    case (out_lane)
      2'd1:    cur_msg = msg_q[0];
      2'd2:    cur_msg = msg_q[1];
      2'd3:    cur_msg = msg_q[2];
      default: cur_msg = '0;
    endcase
    case (first_lane)
      2'd1:    first_msg = ins[0];
      2'd2:    first_msg = ins[1];
      2'd3:    first_msg = ins[2];
      default: first_msg = '0;
    endcase
    case (next_lane)
      2'd1:    next_msg = msg_q[0];
      2'd2:    next_msg = msg_q[1];
      2'd3:    next_msg = msg_q[2];
      default: next_msg = '0;
    endcase
  end

  always_comb begin
    capture  = (state == IDLE) & in_valid;
    hs       = (state == EMIT) & out_ready;
    lane_end = hs & (cnt_q == LAST_IDX);
    set_end  = lane_end & (next_lane == 2'd0);
    cnt_inc  = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture && (cap_mask != 3'b000)) state_nxt = EMIT;
      EMIT:    if (set_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = rst_n & (state == IDLE);
  end

  // Captured templates are only read while EMIT, so they need no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      msg_q[0] <= ins[0];
      msg_q[1] <= ins[1];
      msg_q[2] <= ins[2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q    <= 3'b000;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      out_lane  <= 2'd0;
    end else if (capture) begin
      mask_q <= cap_mask;
      if (cap_mask != 3'b000) begin
        out_valid <= 1'b1;
        out_lane  <= first_lane;
        cnt_q     <= '0;
        out_data  <= get_byte(first_msg, '0);
        out_last  <= (LAST_IDX == '0);
      end
    end else if (hs) begin
      if (!lane_end) begin
        cnt_q    <= cnt_inc;
        out_data <= get_byte(cur_msg, cnt_inc);
        out_last <= (cnt_inc == LAST_IDX);
      end else if (next_lane != 2'd0) begin
        out_lane <= next_lane;
        cnt_q    <= '0;
        out_data <= get_byte(next_msg, '0);
        out_last <= (LAST_IDX == '0);
      end else begin
        mask_q    <= 3'b000;
        cnt_q     <= '0;
        out_valid <= 1'b0;
        out_data  <= 8'h00;
        out_last  <= 1'b0;
        out_lane  <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_bs2_msg_pack.sv
// Scoreboard bench for bs2_msg_pack: expected bytes are queued at capture and
// compared as the DUT hands them over.
module tb_bs2_msg_pack;

  localparam int MSG_BITS = 128;
  localparam int BS2_BITS = 32;
  localparam int BS2_LSB  = 32;
  localparam int NBYTES   = MSG_BITS / 8;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] lane;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                message_en;
  logic                in_valid;
  logic                in_ready;
  logic [MSG_BITS-1:0] message_base_1;
  logic [MSG_BITS-1:0] message_base_2;
  logic [MSG_BITS-1:0] message_base_3;
  logic [BS2_BITS-1:0] BS2_1;
  logic [BS2_BITS-1:0] BS2_2;
  logic [BS2_BITS-1:0] BS2_3;
  logic [2:0]          message_mux_control_m1;
  logic [2:0]          message_mux_control_m2;
  logic [2:0]          message_mux_control_m3;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          out_data;
  logic                out_last;
  logic [1:0]          out_lane;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   pop_count = 0;
  bit   held_flag = 0;
  exp_t held_val;

  bs2_msg_pack #(
    .MSG_BITS(MSG_BITS), .BS2_BITS(BS2_BITS), .BS2_LSB(BS2_LSB),
    .MUX_W(3), .MUX_Q(3'd1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .message_en(message_en),
    .in_valid(in_valid), .in_ready(in_ready),
    .message_base_1(message_base_1), .message_base_2(message_base_2),
    .message_base_3(message_base_3),
    .BS2_1(BS2_1), .BS2_2(BS2_2), .BS2_3(BS2_3),
    .message_mux_control_m1(message_mux_control_m1),
    .message_mux_control_m2(message_mux_control_m2),
    .message_mux_control_m3(message_mux_control_m3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_lane(out_lane)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [MSG_BITS-1:0] modelMsg(input logic [MSG_BITS-1:0] base,
                                                   input logic [BS2_BITS-1:0] bs2);
    logic [MSG_BITS-1:0] m;
    m = base;
    for (int b = 0; b < BS2_BITS; b++) m[BS2_LSB + b] = bs2[b];
    return m;
  endfunction

  task automatic pushMsg(input logic [MSG_BITS-1:0] m, input logic [1:0] lane);
    exp_t e;
    for (int i = 0; i < NBYTES; i++) begin
      e.data = m[MSG_BITS-1-8*i -: 8];
      e.last = (i == NBYTES - 1);
      e.lane = lane;
      sb.push_back(e);
    end
  endtask

  // Monitor: compares every accepted byte and checks stability across stalls.
  always @(negedge clk) begin
    if (rst_n) begin
      if (held_flag) begin
        checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("hold_bytes", {21'd0, out_data, out_last, out_lane}, {21'd0, held_val});
      end
      held_flag = out_valid && !out_ready;
      held_val  = '{data: out_data, last: out_last, lane: out_lane};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_byte", {21'd0, out_data, out_last, out_lane}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          pop_count++;
          checkOutput("byte_data", {24'd0, out_data}, {24'd0, e.data});
          checkOutput("byte_last", {31'd0, out_last}, {31'd0, e.last});
          checkOutput("byte_lane", {30'd0, out_lane}, {30'd0, e.lane});
        end
      end
    end else begin
      held_flag = 0;
    end
  end

  task automatic applyStimulus(input logic en, input logic [2:0] c1, input logic [2:0] c2,
                               input logic [2:0] c3,
                               input logic [MSG_BITS-1:0] b1, input logic [MSG_BITS-1:0] b2,
                               input logic [MSG_BITS-1:0] b3,
                               input logic [BS2_BITS-1:0] s1, input logic [BS2_BITS-1:0] s2,
                               input logic [BS2_BITS-1:0] s3);
    logic [2:0] mask;
    @(posedge clk); #1;
    message_en = en;
    message_mux_control_m1 = c1;
    message_mux_control_m2 = c2;
    message_mux_control_m3 = c3;
    message_base_1 = b1; message_base_2 = b2; message_base_3 = b3;
    BS2_1 = s1; BS2_2 = s2; BS2_3 = s3;
    in_valid = 1'b1;
    checkOutput("in_ready_cap", {31'd0, in_ready}, 32'd1);
    mask = {en & (c3 == 3'd1), en & (c2 == 3'd1), en & (c1 == 3'd1)};
    if (mask[0]) pushMsg(modelMsg(b1, s1), 2'd1);
    if (mask[1]) pushMsg(modelMsg(b2, s2), 2'd2);
    if (mask[2]) pushMsg(modelMsg(b3, s3), 2'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); #1;
    checkOutput("latency_valid", {31'd0, out_valid}, {31'd0, (mask != 3'b000)});
  endtask

  task automatic drainSet(input int budget, input bit bp, output int cycles);
    logic [3:0] pat;
    int idx;
    pat = 4'b1001;
    idx = 0;
    cycles = 0;
    while (sb.size() != 0 && cycles < budget) begin
      @(posedge clk); #1;
      if (bp) begin
        out_ready = pat[idx % 4];
        idx++;
      end
      @(negedge clk); #1;
      cycles++;
    end
    checkOutput("drain_empty", sb.size(), 32'd0);
    @(negedge clk); #1;
    checkOutput("end_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("end_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
  endtask

  logic [MSG_BITS-1:0] baseA, baseB, baseC;
  logic [MSG_BITS-1:0] litMsg;
  int cyc;

  initial begin
    baseA  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    baseB  = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
    baseC  = 128'h13579BDF_02468ACE_FDB97531_ECA86420;
    litMsg = 128'h00112233_44556677_DEADBEEF_CCDDEEFF;

    rst_n = 1'b0; message_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    message_base_1 = '0; message_base_2 = '0; message_base_3 = '0;
    BS2_1 = '0; BS2_2 = '0; BS2_3 = '0;
    message_mux_control_m1 = 3'd0; message_mux_control_m2 = 3'd0;
    message_mux_control_m3 = 3'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_data", {24'd0, out_data}, 32'd0);
    checkOutput("rst_last", {31'd0, out_last}, 32'd0);
    checkOutput("rst_lane", {30'd0, out_lane}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] single lane");
    applyStimulus(1'b1, 3'd1, 3'd0, 3'd0, baseA, baseB, baseC, 32'hDEADBEEF, 32'h1, 32'h2);
    checkOutput("literal_bs2", modelMsg(baseA, 32'hDEADBEEF) == litMsg ? 32'd1 : 32'd0, 32'd1);
    drainSet(100, 1'b0, cyc);
    checkOutput("single_cycles", cyc, NBYTES - 1);

    $display("[TB] lane skip");
    applyStimulus(1'b1, 3'd1, 3'd2, 3'd1, baseA, baseB, baseC, 32'h01020304, 32'hAAAA5555,
                  32'hCAFEF00D);
    drainSet(200, 1'b0, cyc);
    checkOutput("skip_cycles", cyc, 2 * NBYTES - 1);

    $display("[TB] drop");
    applyStimulus(1'b0, 3'd1, 3'd1, 3'd1, baseA, baseB, baseC, 32'h11, 32'h22, 32'h33);
    repeat (3) begin
      @(negedge clk);
      checkOutput("drop_en_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("drop_en_in_ready", {31'd0, in_ready}, 32'd1);
    end
    applyStimulus(1'b1, 3'd0, 3'd2, 3'd7, baseA, baseB, baseC, 32'h11, 32'h22, 32'h33);
    repeat (3) begin
      @(negedge clk);
      checkOutput("drop_ctl_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("drop_ctl_in_ready", {31'd0, in_ready}, 32'd1);
    end

    $display("[TB] backpressure");
    applyStimulus(1'b1, 3'd1, 3'd1, 3'd1, baseC, baseA, baseB, 32'h89ABCDEF, 32'h76543210,
                  32'h0F1E2D3C);
    drainSet(400, 1'b1, cyc);

    $display("[TB] reset mid-message");
    pop_count = 0;
    applyStimulus(1'b1, 3'd1, 3'd1, 3'd1, baseB, baseC, baseA, 32'h5A5A5A5A, 32'hA5A5A5A5,
                  32'h3C3C3C3C);
    cyc = 0;
    while (pop_count < NBYTES + 6 && cyc < 200) begin
      @(negedge clk); #1;
      cyc++;
    end
    checkOutput("reach_lane2_byte5", pop_count, NBYTES + 6);
    rst_n = 1'b0;
    @(negedge clk); #1;
    checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_data", {24'd0, out_data}, 32'd0);
    checkOutput("midrst_last", {31'd0, out_last}, 32'd0);
    checkOutput("midrst_lane", {30'd0, out_lane}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    checkOutput("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midrst_release_valid", {31'd0, out_valid}, 32'd0);
    applyStimulus(1'b1, 3'd0, 3'd1, 3'd0, baseA, baseB, baseC, 32'h1, 32'hFEEDFACE, 32'h3);
    drainSet(100, 1'b0, cyc);
    checkOutput("restart_cycles", cyc, NBYTES - 1);

    $display("[TB] input change during emit");
    applyStimulus(1'b1, 3'd1, 3'd0, 3'd1, baseA, baseB, baseC, 32'h0BADC0DE, 32'h2, 32'h600DF00D);
    repeat (2) @(posedge clk);
    #1;
    message_base_1 = ~baseA;
    BS2_1 = 32'h12345678;
    message_base_3 = baseB;
    in_valid = 1'b1;
    checkOutput("in_ready_emit", {31'd0, in_ready}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    drainSet(200, 1'b0, cyc);

    checkOutput("final_queue", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
